// File: rtl/axon_array_if.sv
// -----------------------------------------------------------------------------
// axon_array_if
// Purpose : Bundles the tile-request handshake and the array/buffer control
//           outputs of axon_array_ctrl into one interface.
// Modports: master - layer scheduler / testbench side (drives start, k_len)
//           slave  - axon_array_ctrl side (drives all status and control)
// Signals : start, k_len            tile request and reduction length
//           busy, done              tile status
//           psum_clr, feed_en,
//           feed_idx                PE clear and operand injection control
//           eject_ctrl, out_valid,
//           out_col_idx             output-chain eject/shift control
// -----------------------------------------------------------------------------
interface axon_array_if #(
  parameter int COLS    = 4,
  parameter int K_WIDTH = 8
);
  localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;

  logic               start;
  logic [K_WIDTH-1:0] k_len;
  logic               busy;
  logic               done;
  logic               psum_clr;
  logic               feed_en;
  logic [K_WIDTH-1:0] feed_idx;
  logic [COLS-1:0]    eject_ctrl;
  logic               out_valid;
  logic [CW-1:0]      out_col_idx;

  modport master (
    output start, k_len,
    input  busy, done, psum_clr, feed_en, feed_idx,
    input  eject_ctrl, out_valid, out_col_idx
  );

  modport slave (
    input  start, k_len,
    output busy, done, psum_clr, feed_en, feed_idx,
    output eject_ctrl, out_valid, out_col_idx
  );
endinterface

// File: rtl/axon_array_ctrl.sv
// -----------------------------------------------------------------------------
// axon_array_ctrl
// Purpose : Per-tile sequencer for a ROWS x COLS output-stationary PE array.
//           IDLE -> CLEAR (1) -> FEED (K) -> DRAIN (ROWS+COLS) -> EJECT (1)
//           -> SHIFT (COLS) -> DONE (1) -> IDLE.
// Ports   : clk  - rising-edge clock
//           rst  - asynchronous active-high reset, aborts any tile silently
//           bus  - axon_array_if.slave: start/k_len in; busy, done, psum_clr,
//                  feed_en, feed_idx, eject_ctrl, out_valid, out_col_idx out
// All outputs are flops loaded from the next-state decode, so each output
// appears in the same cycle the FSM enters the corresponding state and there
// is no combinational path from start/k_len to any output.
// -----------------------------------------------------------------------------
module axon_array_ctrl #(
  parameter int ROWS    = 4,
  parameter int COLS    = 4,
  parameter int K_WIDTH = 8
) (
  input logic          clk,
  input logic          rst,
  axon_array_if.slave  bus
);
  localparam int CW     = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int SPAN_W = $clog2(ROWS + COLS + 1);
  // One counter serves FEED, DRAIN and SHIFT, so it must hold K-1 as well
  // as ROWS+COLS-1.
  localparam int CNT_W  = (K_WIDTH > SPAN_W) ? K_WIDTH : SPAN_W;

  localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(ROWS + COLS - 1);
  localparam logic [CNT_W-1:0] SHIFT_LAST = CNT_W'(COLS - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_FEED  = 3'd2,
    S_DRAIN = 3'd3,
    S_EJECT = 3'd4,
    S_SHIFT = 3'd5,
    S_DONE  = 3'd6
  } state_t;

  state_t             state_r, state_nx;
  logic [CNT_W-1:0]   cnt_r, cnt_nx;
  logic [K_WIDTH-1:0] k_r, k_nx;
  logic [CNT_W-1:0]   k_last_s;

  logic               busy_r, busy_nx;
  logic               done_r, done_nx;
  logic               psum_clr_r, psum_clr_nx;
  logic               feed_en_r, feed_en_nx;
  logic [K_WIDTH-1:0] feed_idx_r, feed_idx_nx;
  logic [COLS-1:0]    eject_ctrl_r, eject_ctrl_nx;
  logic               out_valid_r, out_valid_nx;
  logic [CW-1:0]      out_col_idx_r, out_col_idx_nx;

  // Last FEED index; only consulted when K != 0, so the K=0 underflow is harmless.
  assign k_last_s = CNT_W'(k_r) - CNT_W'(1);

  // Next-state, counter and latched-K decode.
  always_comb begin
    state_nx = state_r;
    cnt_nx   = cnt_r;
    k_nx     = k_r;
    case (state_r)
      S_IDLE: begin
        if (bus.start) begin
          state_nx = S_CLEAR;
          k_nx     = bus.k_len;
          cnt_nx   = {CNT_W{1'b0}};
        end else begin
          state_nx = S_IDLE;
        end
      end
      S_CLEAR: begin
        cnt_nx = {CNT_W{1'b0}};
        if (k_r == {K_WIDTH{1'b0}}) begin
          state_nx = S_DRAIN;
        end else begin
          state_nx = S_FEED;
        end
      end
      S_FEED: begin
        if (cnt_r == k_last_s) begin
          state_nx = S_DRAIN;
          cnt_nx   = {CNT_W{1'b0}};
        end else begin
          cnt_nx   = cnt_r + CNT_W'(1);
        end
      end
      S_DRAIN: begin
        if (cnt_r == DRAIN_LAST) begin
          state_nx = S_EJECT;
          cnt_nx   = {CNT_W{1'b0}};
        end else begin
          cnt_nx   = cnt_r + CNT_W'(1);
        end
      end
      S_EJECT: begin
        state_nx = S_SHIFT;
        cnt_nx   = {CNT_W{1'b0}};
      end
      S_SHIFT: begin
        if (cnt_r == SHIFT_LAST) begin
          state_nx = S_DONE;
          cnt_nx   = {CNT_W{1'b0}};
        end else begin
          cnt_nx   = cnt_r + CNT_W'(1);
        end
      end
      S_DONE: begin
        state_nx = S_IDLE;
        cnt_nx   = {CNT_W{1'b0}};
      end
      default: begin
        state_nx = S_IDLE;
        cnt_nx   = {CNT_W{1'b0}};
        k_nx     = {K_WIDTH{1'b0}};
      end
    endcase
  end

  // Output decode from the state being entered, so the flopped outputs line up with the state.
  always_comb begin
    busy_nx        = (state_nx != S_IDLE);
    done_nx        = (state_nx == S_DONE);
    psum_clr_nx    = (state_nx == S_CLEAR);
    feed_en_nx     = (state_nx == S_FEED);
    out_valid_nx   = (state_nx == S_SHIFT);
    feed_idx_nx    = {K_WIDTH{1'b0}};
    eject_ctrl_nx  = {COLS{1'b0}};
    out_col_idx_nx = {CW{1'b0}};
    if (state_nx == S_FEED) begin
      feed_idx_nx = cnt_nx[K_WIDTH-1:0];
    end else begin
      feed_idx_nx = {K_WIDTH{1'b0}};
    end
    if (state_nx == S_EJECT) begin
      eject_ctrl_nx = {COLS{1'b1}};
    end else begin
      eject_ctrl_nx = {COLS{1'b0}};
    end
    // The edge column leaves the chain first, so the index counts down.
    if (state_nx == S_SHIFT) begin
      out_col_idx_nx = CW'(SHIFT_LAST - cnt_nx);
    end else begin
      out_col_idx_nx = {CW{1'b0}};
    end
  end

  // State, counter and latched-K registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= S_IDLE;
      cnt_r   <= {CNT_W{1'b0}};
      k_r     <= {K_WIDTH{1'b0}};
    end else begin
      state_r <= state_nx;
      cnt_r   <= cnt_nx;
      k_r     <= k_nx;
    end
  end

  // Output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_r        <= 1'b0;
      done_r        <= 1'b0;
      psum_clr_r    <= 1'b0;
      feed_en_r     <= 1'b0;
      feed_idx_r    <= {K_WIDTH{1'b0}};
      eject_ctrl_r  <= {COLS{1'b0}};
      out_valid_r   <= 1'b0;
      out_col_idx_r <= {CW{1'b0}};
    end else begin
      busy_r        <= busy_nx;
      done_r        <= done_nx;
      psum_clr_r    <= psum_clr_nx;
      feed_en_r     <= feed_en_nx;
      feed_idx_r    <= feed_idx_nx;
      eject_ctrl_r  <= eject_ctrl_nx;
      out_valid_r   <= out_valid_nx;
      out_col_idx_r <= out_col_idx_nx;
    end
  end

  assign bus.busy        = busy_r;
  assign bus.done        = done_r;
  assign bus.psum_clr    = psum_clr_r;
  assign bus.feed_en     = feed_en_r;
  assign bus.feed_idx    = feed_idx_r;
  assign bus.eject_ctrl  = eject_ctrl_r;
  assign bus.out_valid   = out_valid_r;
  assign bus.out_col_idx = out_col_idx_r;
endmodule

// File: tb/tb_axon_array_ctrl.sv
// -----------------------------------------------------------------------------
// tb_axon_array_ctrl
// Purpose : Self-checking bench for axon_array_ctrl. Each accepted start is
//           expanded into the list of control events the tile must produce,
//           each stamped with the clock edge after which it must be visible.
//           A monitor pops and compares whenever the DUT shows a control.
// -----------------------------------------------------------------------------
module tb_axon_array_ctrl;
  localparam int ROWS = 4;
  localparam int COLS = 4;
  localparam int KW   = 8;

  localparam int EV_CLR   = 1;
  localparam int EV_FEED  = 2;
  localparam int EV_EJECT = 3;
  localparam int EV_BEAT  = 4;
  localparam int EV_DONE  = 5;

  typedef struct {
    int kind;
    int val;
    int when;
  } ev_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  axon_array_if #(.COLS(COLS), .K_WIDTH(KW)) bus ();

  axon_array_ctrl #(.ROWS(ROWS), .COLS(COLS), .K_WIDTH(KW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  ev_t q[$];
  int  checks    = 0;
  int  failures  = 0;
  int  edge_cnt  = 0;
  int  next_ok   = 0;
  int  cur_start = 0;
  int  busy_end  = -1;
  int  mon_n, mon_kind, mon_val;
  ev_t mon_ev;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, edge_cnt);
    end
  endtask

  task automatic push(input int kind, input int val, input int when);
    ev_t e;
    e.kind = kind;
    e.val  = val;
    e.when = when;
    q.push_back(e);
  endtask

  // Tile accepted at edge e with length k: timeline from the tile rules.
  task automatic schedule(input int e, input int k);
    int t_total;
    t_total = k + 3 + ROWS + 2 * COLS;
    push(EV_CLR, 1, e);
    for (int j = 0; j < k; j++) push(EV_FEED, j, e + 1 + j);
    push(EV_EJECT, (1 << COLS) - 1, e + k + 1 + ROWS + COLS);
    for (int j = 0; j < COLS; j++) push(EV_BEAT, COLS - 1 - j, e + k + 2 + ROWS + COLS + j);
    push(EV_DONE, 1, e + t_total - 1);
    cur_start = e;
    busy_end  = e + t_total - 1;
    next_ok   = e + t_total + 1;
  endtask

  task automatic drive(input bit s, input int k);
    @(negedge clk);
    bus.start = s;
    bus.k_len = k[KW-1:0];
    if (s && (edge_cnt + 1 >= next_ok)) schedule(edge_cnt + 1, k);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, $urandom_range(0, 255));
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2;
    rst = 1'b1;
    bus.start = 1'b0;
    #1;
    check("rst_outputs", {bus.busy, bus.done, bus.psum_clr, bus.feed_en, bus.feed_idx,
                          bus.eject_ctrl, bus.out_valid, bus.out_col_idx}, 32'd0);
    q.delete();
    cur_start = 0;
    busy_end  = -1;
    next_ok   = 0;
    repeat (3) @(negedge clk);
    #2;
    rst = 1'b0;
  endtask

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  // Monitor: every visible control must match the head of the expected queue.
  always @(negedge clk) begin
    if (!rst) begin
      mon_n = 0;
      mon_kind = 0;
      mon_val = 0;
      if (bus.psum_clr) begin mon_n++; mon_kind = EV_CLR; mon_val = 1; end
      if (bus.feed_en) begin mon_n++; mon_kind = EV_FEED; mon_val = int'(bus.feed_idx); end
      if (bus.eject_ctrl != '0) begin mon_n++; mon_kind = EV_EJECT; mon_val = int'(bus.eject_ctrl); end
      if (bus.out_valid) begin mon_n++; mon_kind = EV_BEAT; mon_val = int'(bus.out_col_idx); end
      if (bus.done) begin mon_n++; mon_kind = EV_DONE; mon_val = 1; end
      check("busy", bus.busy, (edge_cnt >= cur_start && edge_cnt <= busy_end) ? 32'd1 : 32'd0);
      check("one_ctrl", (mon_n <= 1), 32'd1);
      if (mon_n > 0) begin
        if (q.size() == 0) begin
          check("unexpected_ctrl_kind", mon_kind, 32'd0);
        end else begin
          mon_ev = q.pop_front();
          check("ctrl_kind", mon_kind, mon_ev.kind);
          check("ctrl_edge", edge_cnt, mon_ev.when);
          check("ctrl_value", mon_val, mon_ev.val);
        end
      end else if (q.size() > 0 && q[0].when <= edge_cnt) begin
        mon_ev = q.pop_front();
        check("missing_ctrl_kind", 32'd0, mon_ev.kind);
      end
    end
  end

  initial begin
    bus.start = 1'b0;
    bus.k_len = '0;
    do_reset();
    idle(2);

    // K=3: clear, three feeds, eject, four beats, done.
    drive(1'b1, 3);
    idle(25);
    // K=0: no feed cycles at all.
    drive(1'b1, 0);
    idle(20);
    // K=1 boundary.
    drive(1'b1, 1);
    idle(20);
    // start held high across several tiles: back-to-back acceptance after DONE.
    for (int i = 0; i < 60; i++) drive(1'b1, 2);
    idle(25);
    // Extra start pulse mid-FEED must be ignored.
    drive(1'b1, 6);
    idle(3);
    drive(1'b1, 9);
    idle(25);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) drive(($urandom_range(0, 99) < 30), $urandom_range(0, 20));
    idle(40);

    // Reset in the middle of SHIFT: outputs drop at once, no done follows.
    drive(1'b1, 2);
    for (int i = 0; i < 60 && !bus.out_valid; i++) drive(1'b0, 0);
    check("shift_reached", bus.out_valid, 32'd1);
    do_reset();
    idle(10);
    drive(1'b1, 1);
    idle(25);

    // Maximum K: counter must run the full 255 feeds without wrapping.
    drive(1'b1, 255);
    idle(285);

    for (int i = 0; i < 600 && q.size() > 0; i++) @(negedge clk);
    check("queue_drained", q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
